// File: rtl/score_display_pkg.sv
// Shared definitions for the score display controller.
//   state_t   : controller FSM encoding (IDLE / SHIFT / LOAD)
//   SEG_BLANK : active-low pattern for an unlit 7-segment digit
//   MAX_SCORE : largest score the six-digit display can show
//   dd_adj    : double-dabble nibble correction (+3 when >= 5)
package score_display_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LOAD  = 2'd2
  } state_t;

  localparam logic [6:0]  SEG_BLANK = 7'h7F;
  localparam logic [19:0] MAX_SCORE = 20'd999999;

  // A BCD nibble of 5..9 would exceed 9 after the next doubling, so it is
  // pre-corrected by +3 to carry into the next decimal digit on the shift.
  function automatic logic [3:0] dd_adj(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

endpackage

// File: rtl/score_display_ctrl_hex_decoder.sv
// hex_decoder: one hex digit to active-low 7-segment pattern.
//   sw  [3:0] : digit value 0..F
//   hex [6:0] : segments {g,f,e,d,c,b,a}, 0 = lit
module hex_decoder (
  input  logic [3:0] sw,
  output logic [6:0] hex
);

  always_comb begin
    hex = 7'h7F;
    case (sw)
      4'h0: hex = 7'b1000000;
      4'h1: hex = 7'b1111001;
      4'h2: hex = 7'b0100100;
      4'h3: hex = 7'b0110000;
      4'h4: hex = 7'b0011001;
      4'h5: hex = 7'b0010010;
      4'h6: hex = 7'b0000010;
      4'h7: hex = 7'b1111000;
      4'h8: hex = 7'b0000000;
      4'h9: hex = 7'b0010000;
      4'hA: hex = 7'b0001000;
      4'hB: hex = 7'b0000011;
      4'hC: hex = 7'b1000110;
      4'hD: hex = 7'b0100001;
      4'hE: hex = 7'b0000110;
      4'hF: hex = 7'b0001110;
      default: hex = 7'h7F;
    endcase
  end

endmodule

// File: rtl/score_display_ctrl.sv
// score_display_ctrl: binary score -> six 7-segment digits.
// A score is taken over a valid/ready handshake, clamped to 999999,
// converted by iterative double-dabble (one bit per cycle) and latched into
// the digit register in one step, so the displays never show partial digits.
//   clock, reset       : system clock, synchronous active-high reset
//   score, score_valid : producer side, score sampled on accept
//   score_ready        : high in IDLE
//   busy               : conversion running
//   done               : one-cycle pulse while new digits are being latched
//   HEX0..HEX5         : active-low segments, HEX0 = least significant digit
module score_display_ctrl
  import score_display_pkg::*;
#(
  parameter int BIN_W    = 20,
  parameter int DIGITS   = 6,
  parameter int BLANK_LZ = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [BIN_W-1:0] score,
  input  logic             score_valid,
  output logic             score_ready,
  output logic             busy,
  output logic             done,
  output logic [6:0]       HEX0,
  output logic [6:0]       HEX1,
  output logic [6:0]       HEX2,
  output logic [6:0]       HEX3,
  output logic [6:0]       HEX4,
  output logic [6:0]       HEX5
);

  localparam int               CNT_W    = $clog2(BIN_W);
  localparam int               SH_W     = 4*DIGITS + BIN_W;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W-1);
  localparam logic [BIN_W-1:0] MAX_W    = BIN_W'(MAX_SCORE);

  state_t                   state, state_nxt;
  logic [BIN_W-1:0]         bin_sh;
  logic [DIGITS-1:0][3:0]   bcd_sh, bcd_adj, digits;
  logic [CNT_W-1:0]         cnt;
  logic [BIN_W-1:0]         score_sat;
  logic [SH_W-1:0]          sh_cat, sh_nxt;
  logic                     accept;

  assign score_sat = (score > MAX_W) ? MAX_W : score;
  assign accept    = score_valid & score_ready;

  // ---------------- FSM ----------------
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (score_valid)     state_nxt = SHIFT;
      SHIFT:   if (cnt == CNT_LAST) state_nxt = LOAD;
      LOAD:                         state_nxt = IDLE;
      default:                      state_nxt = IDLE;
    endcase
  end

  // Moore outputs decoded straight from the state register.
  always_comb begin
    score_ready = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    case (state)
      IDLE:    score_ready = 1'b1;
      SHIFT:   busy        = 1'b1;
      LOAD:    done        = 1'b1;
      default: ;
    endcase
  end

  // ---------------- double-dabble datapath ----------------
  always_comb begin
    bcd_adj = bcd_sh;
    for (int i = 0; i < DIGITS; i++) bcd_adj[i] = dd_adj(bcd_sh[i]);
  end

  // Corrected BCD and remaining binary shift left together as one register.
  assign sh_cat = {bcd_adj, bin_sh};
  assign sh_nxt = {sh_cat[SH_W-2:0], 1'b0};

  always_ff @(posedge clock) begin
    if (reset) begin
      bin_sh <= '0;
      bcd_sh <= '0;
      cnt    <= '0;
      digits <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          bin_sh <= score_sat;
          bcd_sh <= '0;
          cnt    <= '0;
        end
        SHIFT: begin
          {bcd_sh, bin_sh} <= sh_nxt;
          cnt              <= cnt + 1'b1;
        end
        LOAD:    digits <= bcd_sh;
        default: ;
      endcase
    end
  end

  // ---------------- segment decode + leading-zero blanking ----------------
  // lz[i]: digit i and every higher digit are zero.
  logic [DIGITS:0]        lz;
  logic [DIGITS-1:0][6:0] seg_raw, seg;

  assign lz[DIGITS] = 1'b1;

  for (genvar i = 0; i < DIGITS; i++) begin : g_dig
    assign lz[i] = (digits[i] == 4'd0) & lz[i+1];

    hex_decoder u_hex (
      .sw  (digits[i]),
      .hex (seg_raw[i])
    );

    if (i == 0 || BLANK_LZ == 0) begin : g_lit
      assign seg[i] = seg_raw[i];
    end else begin : g_blank
      assign seg[i] = lz[i] ? SEG_BLANK : seg_raw[i];
    end
  end

  // lz[0] only terminates the chain; digit 0 is never blanked.
  logic unused_lz0;
  assign unused_lz0 = lz[0];

  assign HEX0 = seg[0];
  assign HEX1 = seg[1];
  assign HEX2 = seg[2];
  assign HEX3 = seg[3];
  assign HEX4 = seg[4];
  assign HEX5 = seg[5];

endmodule

// File: tb/tb_score_display_ctrl.sv
module tb_score_display_ctrl;

  localparam int BIN_W = 20;
  localparam logic [41:0] RST_DISP = {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'b1000000};

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [19:0] score = '0;
  logic        score_valid = 1'b0;
  logic        score_ready, busy, done;
  logic [6:0]  HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;

  int total = 0;
  int bad   = 0;
  logic [41:0] cur_disp;

  score_display_ctrl #(.BIN_W(20), .DIGITS(6), .BLANK_LZ(1)) dut (
    .clock(clock), .reset(reset), .score(score), .score_valid(score_valid),
    .score_ready(score_ready), .busy(busy), .done(done),
    .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3), .HEX4(HEX4), .HEX5(HEX5)
  );

  always #5 clock = ~clock;

  function automatic logic [41:0] disp();
    return {HEX5, HEX4, HEX3, HEX2, HEX1, HEX0};
  endfunction

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'b1000000;  1: return 7'b1111001;
      2: return 7'b0100100;  3: return 7'b0110000;
      4: return 7'b0011001;  5: return 7'b0010010;
      6: return 7'b0000010;  7: return 7'b1111000;
      8: return 7'b0000000;  9: return 7'b0010000;
      default: return 7'h7F;
    endcase
  endfunction

  // Reference: clamp, split into decimal digits arithmetically, blank any
  // position above the most significant nonzero digit.
  function automatic logic [41:0] model_disp(input int unsigned v);
    int unsigned sat, p;
    logic [41:0] r;
    sat = (v > 999999) ? 999999 : v;
    p = 1;
    r = '0;
    for (int i = 0; i < 6; i++) begin
      if (i > 0 && sat < p) r[i*7 +: 7] = 7'h7F;
      else                  r[i*7 +: 7] = seg_of(int'((sat / p) % 10));
      p = p * 10;
    end
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_ready(input string nm);
    int n = 0;
    while (score_ready !== 1'b1 && n < 50) begin tick(); n++; end
    chk({nm, "_ready_to"}, 64'(n < 50), 64'd1);
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (done !== 1'b1 && n < 60) begin tick(); n++; end
  endtask

  // One complete transaction with latency, hold and result checks.
  task automatic run_score(input logic [19:0] v, input logic [41:0] exp, input string nm);
    int n;
    score = v;
    score_valid = 1'b1;
    wait_ready(nm);
    tick();                        // accept edge
    score_valid = 1'b0;
    chk({nm, "_busy"},  64'(busy), 64'd1);
    chk({nm, "_ready"}, 64'(score_ready), 64'd0);
    wait_done(n);
    chk({nm, "_lat"},  64'(n), 64'(BIN_W));
    chk({nm, "_hold"}, 64'(disp()), 64'(cur_disp));
    tick();
    chk({nm, "_pulse"}, 64'(done), 64'd0);
    chk({nm, "_rdy2"},  64'(score_ready), 64'd1);
    chk({nm, "_disp"},  64'(disp()), 64'(exp));
    cur_disp = exp;
  endtask

  typedef struct {
    logic [19:0] sc;
    logic [41:0] exp;
  } vec_t;

  vec_t vt[7];

  initial begin
    int n, dones;
    logic [19:0] r;

    vt[0] = '{20'd1234,   {7'h7F, 7'h7F, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001}};
    vt[1] = '{20'hFFFFF,  {6{7'b0010000}}};
    vt[2] = '{20'd0,      RST_DISP};
    vt[3] = '{20'd999999, {6{7'b0010000}}};
    vt[4] = '{20'd100000, {7'b1111001, 7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000}};
    vt[5] = '{20'd5,      {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'b0010010}};
    vt[6] = '{20'd10,     {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'b1111001, 7'b1000000}};

    // Reset state
    tick(); tick();
    reset = 1'b0;
    tick();
    chk("rst_disp",  64'(disp()), 64'(RST_DISP));
    chk("rst_ready", 64'(score_ready), 64'd1);
    chk("rst_busy",  64'(busy), 64'd0);
    chk("rst_done",  64'(done), 64'd0);
    cur_disp = RST_DISP;

    // Directed table (1234, saturation, zero after nonzero, boundaries)
    for (int i = 0; i < 7; i++) run_score(vt[i].sc, vt[i].exp, $sformatf("vec%0d", i));

    // score_valid held through busy with a changing score
    score = 20'd500;
    score_valid = 1'b1;
    wait_ready("hold");
    tick();
    score = 20'd501;               // valid stays high
    chk("hold_busy", 64'(busy), 64'd1);
    dones = 0;
    wait_done(n);
    if (done === 1'b1) dones++;
    tick();
    chk("hold_first", 64'(disp()), 64'(model_disp(500)));
    chk("hold_rdy",   64'(score_ready), 64'd1);
    tick();                        // 501 accepted here
    score_valid = 1'b0;
    chk("hold_busy2", 64'(busy), 64'd1);
    wait_done(n);
    if (done === 1'b1) dones++;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (done === 1'b1) dones++;
    end
    chk("hold_dones", 64'(dones), 64'd2);
    chk("hold_final", 64'(disp()), 64'(model_disp(501)));
    cur_disp = model_disp(501);

    // Reset during the 10th SHIFT cycle
    score = 20'd777;
    score_valid = 1'b1;
    wait_ready("abort");
    tick();
    score_valid = 1'b0;
    dones = 0;
    for (int i = 0; i < 9; i++) begin
      if (done === 1'b1) dones++;
      tick();
    end
    chk("abort_busy", 64'(busy), 64'd1);
    chk("abort_held", 64'(disp()), 64'(cur_disp));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) if (done === 1'b1) dones++;
    chk("abort_nodone", 64'(dones), 64'd0);
    chk("abort_disp",   64'(disp()), 64'(RST_DISP));
    chk("abort_ready",  64'(score_ready), 64'd1);
    chk("abort_busy0",  64'(busy), 64'd0);
    cur_disp = RST_DISP;
    run_score(20'd42, model_disp(42), "after_abort");

    // Randomized scores against the reference model
    for (int i = 0; i < 40; i++) begin
      r = 20'($urandom);
      if (i % 4 == 0) r = 20'($urandom_range(0, 999));
      run_score(r, model_disp(int'(r)), $sformatf("rnd%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
